// File: rtl/bullet_pool.sv
// Pool of NUM_BULLETS upward-moving bullets with cooldown-limited fire from the ship position.
// Optional macro BULLET_POOL_EDGE_FIRE_EN: fire only on a fresh key press instead of hold-to-repeat.
module bullet_pool #(
    parameter int unsigned NUM_BULLETS  = 4,
    parameter int unsigned BULLET_SPEED = 8,
    parameter int unsigned BULLET_SIZE  = 3,
    parameter int unsigned BULLET_Y_MIN = 15,
    parameter int unsigned COOLDOWN     = 6,
    parameter logic [7:0]  FIRE_KEY     = 8'h2c
) (
    input  logic                      frame_clk,
    input  logic                      Reset,
    input  logic [9:0]                ship_X,
    input  logic [9:0]                ship_Y,
    input  logic [23:0]               space_key,
    input  logic [NUM_BULLETS-1:0]    bullet_hit,
    output logic [NUM_BULLETS-1:0]    bullet_active,
    output logic [10*NUM_BULLETS-1:0] bullet_X_out,
    output logic [10*NUM_BULLETS-1:0] bullet_Y_out,
    output logic [9:0]                bullet_size,
    output logic                      fire_pulse,
    output logic [4:0]                active_count
);

    localparam int unsigned CD_W     = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [9:0]  RETIRE_Y = 10'(BULLET_Y_MIN + (BULLET_SPEED >> 2) + BULLET_SIZE);
    localparam logic [9:0]  SPEED    = 10'(BULLET_SPEED);
    localparam logic [9:0]  Y_MIN    = 10'(BULLET_Y_MIN);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

    logic [NUM_BULLETS-1:0] active_q, active_d;
    logic [9:0]             x_q [NUM_BULLETS];
    logic [9:0]             x_d [NUM_BULLETS];
    logic [9:0]             y_q [NUM_BULLETS];
    logic [9:0]             y_d [NUM_BULLETS];
    logic [CD_W-1:0]        cooldown_q, cooldown_d;
    logic                   fire_pulse_q, fire_pulse_d;
    logic [4:0]             active_count_q, active_count_d;
    logic                   key_down;
    logic                   fire_trigger;
    logic                   fire;
    logic                   slot_found;

    assign key_down = (space_key[23:16] == FIRE_KEY) ||
                      (space_key[15:8]  == FIRE_KEY) ||
                      (space_key[7:0]   == FIRE_KEY);

`ifdef BULLET_POOL_EDGE_FIRE_EN
    logic key_down_q, key_down_d;
    assign key_down_d   = key_down;
    assign fire_trigger = key_down && !key_down_q;
`else
    assign fire_trigger = key_down;
`endif

    // Free slots come from the registered state, so a slot retiring this frame cannot be reused yet.
    assign fire = fire_trigger && (cooldown_q == '0) && (ship_Y > Y_MIN) && !(&active_q);

    always_comb begin
        active_d       = active_q;
        slot_found     = 1'b0;
        active_count_d = '0;
        for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
            x_d[i] = x_q[i];
            y_d[i] = y_q[i];
            if (active_q[i]) begin
                if (bullet_hit[i] || (y_q[i] < RETIRE_Y)) begin
                    active_d[i] = 1'b0;
                end else begin
                    y_d[i] = y_q[i] - SPEED;
                end
            end else if (fire && !slot_found) begin
                slot_found  = 1'b1;
                active_d[i] = 1'b1;
                x_d[i]      = ship_X;
                y_d[i]      = ship_Y;
            end
        end
        for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
            active_count_d = active_count_d + 5'(active_d[i]);
        end
        if (fire) begin
            cooldown_d = CD_LOAD;
        end else if (cooldown_q != '0) begin
            cooldown_d = cooldown_q - CD_W'(1);
        end else begin
            cooldown_d = '0;
        end
        fire_pulse_d = fire;
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            active_q       <= '0;
            cooldown_q     <= '0;
            fire_pulse_q   <= 1'b0;
            active_count_q <= '0;
            for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
`ifdef BULLET_POOL_EDGE_FIRE_EN
            key_down_q     <= 1'b0;
`endif
        end else begin
            active_q       <= active_d;
            cooldown_q     <= cooldown_d;
            fire_pulse_q   <= fire_pulse_d;
            active_count_q <= active_count_d;
            for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
`ifdef BULLET_POOL_EDGE_FIRE_EN
            key_down_q     <= key_down_d;
`endif
        end
    end

    always_comb begin
        bullet_X_out = '0;
        bullet_Y_out = '0;
        for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
            bullet_X_out[10*i +: 10] = x_q[i];
            bullet_Y_out[10*i +: 10] = y_q[i];
        end
    end

    assign bullet_active = active_q;
    assign bullet_size   = 10'(BULLET_SIZE);
    assign fire_pulse    = fire_pulse_q;
    assign active_count  = active_count_q;

endmodule

// File: tb/tb_bullet_pool.sv
// Randomised and directed bench for bullet_pool against a frame-level behavioural model.
module tb_bullet_pool;

    localparam int N = 4;

    logic              frame_clk = 1'b0;
    logic              Reset;
    logic [9:0]        ship_X, ship_Y;
    logic [23:0]       space_key;
    logic [N-1:0]      bullet_hit;
    logic [N-1:0]      bullet_active;
    logic [10*N-1:0]   bullet_X_out, bullet_Y_out;
    logic [9:0]        bullet_size;
    logic              fire_pulse;
    logic [4:0]        active_count;

    bullet_pool #(.NUM_BULLETS(N)) dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .ship_X       (ship_X),
        .ship_Y       (ship_Y),
        .space_key    (space_key),
        .bullet_hit   (bullet_hit),
        .bullet_active(bullet_active),
        .bullet_X_out (bullet_X_out),
        .bullet_Y_out (bullet_Y_out),
        .bullet_size  (bullet_size),
        .fire_pulse   (fire_pulse),
        .active_count (active_count)
    );

    always #5 frame_clk = ~frame_clk;

    int checks   = 0;
    int failures = 0;

    // Reference state, one entry per slot, plain integers.
    bit m_act [N];
    int m_x   [N];
    int m_y   [N];
    int m_cd;
    bit m_pulse;
    bit m_kd_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit key_is_down(input logic [23:0] k);
        return (k[7:0] == 8'h2c) || (k[15:8] == 8'h2c) || (k[23:16] == 8'h2c);
    endfunction

    function automatic logic [23:0] make_key(input bit down);
        logic [23:0] k;
        int pos;
        k = 24'($urandom);
        for (int b = 0; b < 3; b++)
            if (k[8*b +: 8] == 8'h2c) k[8*b +: 8] = 8'h2d;
        if (down) begin
            pos = $urandom_range(0, 2);
            k[8*pos +: 8] = 8'h2c;
        end
        return k;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0;
            m_x[i]   = 0;
            m_y[i]   = 0;
        end
        m_cd      = 0;
        m_pulse   = 0;
        m_kd_prev = 0;
    endtask

    task automatic model_frame();
        bit kd, trig, fire;
        int slot;
        kd   = key_is_down(space_key);
        slot = -1;
        for (int i = N - 1; i >= 0; i--)
            if (!m_act[i]) slot = i;
        trig = kd;
`ifdef BULLET_POOL_EDGE_FIRE_EN
        trig = kd && !m_kd_prev;
`endif
        m_kd_prev = kd;
        fire = trig && (m_cd == 0) && (int'(ship_Y) > 15) && (slot >= 0);
        for (int i = 0; i < N; i++) begin
            if (m_act[i]) begin
                if (bullet_hit[i] || m_y[i] < 20) m_act[i] = 0;
                else m_y[i] = (m_y[i] + 1024 - 8) % 1024;
            end
        end
        if (fire) begin
            m_act[slot] = 1;
            m_x[slot]   = int'(ship_X);
            m_y[slot]   = int'(ship_Y);
            m_cd        = 6;
        end else if (m_cd > 0) begin
            m_cd = m_cd - 1;
        end
        m_pulse = fire;
    endtask

    task automatic compare_all(input string tag);
        logic [N-1:0] ev;
        int cnt;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            ev[i] = m_act[i];
            cnt += int'(m_act[i]);
        end
        check({tag, ".active"}, 32'(bullet_active), 32'(ev));
        check({tag, ".count"}, 32'(active_count), cnt);
        check({tag, ".pulse"}, 32'(fire_pulse), 32'(m_pulse));
        check({tag, ".size"}, 32'(bullet_size), 3);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s.x%0d", tag, i), 32'(bullet_X_out[10*i +: 10]), m_x[i]);
            check($sformatf("%s.y%0d", tag, i), 32'(bullet_Y_out[10*i +: 10]), m_y[i]);
        end
    endtask

    task automatic frame_step(input string tag);
        model_frame();
        @(posedge frame_clk);
        #1;
        compare_all(tag);
    endtask

    // Called at 1 time unit after a rising edge; reset pulse stays clear of both clock edges.
    task automatic do_reset(input string tag);
        #1;
        Reset = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        #1;
        Reset = 1'b1;
    endtask

    int pulses;
    int exp_pulses;

    initial begin
        Reset      = 1'b0;
        ship_X     = '0;
        ship_Y     = '0;
        space_key  = '0;
        bullet_hit = '0;
        model_reset();
        #2;
        compare_all("por");
        @(posedge frame_clk);
        #1;
        Reset = 1'b1;

        // Mid-flight asynchronous reset with two slots in flight.
        ship_X    = 10'd100;
        ship_Y    = 10'd300;
        space_key = make_key(1);
        for (int k = 0; k < 8; k++) frame_step("pre_rst");
        check("two_active", 32'(bullet_active), 32'h3);
        do_reset("mid_rst");
        frame_step("post_rst");
        check("post_rst_slot0", 32'(bullet_active), 32'h1);

        // Held key: shots every 7 frames, then pool full, then hit-driven refire.
        @(posedge frame_clk); #1;
        do_reset("rst_b");
        ship_X    = 10'd320;
        ship_Y    = 10'd400;
        space_key = make_key(1);
        pulses    = 0;
        for (int k = 0; k < 20; k++) begin
            frame_step("hold");
            pulses += int'(fire_pulse);
            if (k == 0) check("hold_y0_f0", 32'(bullet_Y_out[9:0]), 400);
            if (k == 1) check("hold_y0_f1", 32'(bullet_Y_out[9:0]), 392);
            if (k == 14) check("hold_slots", 32'(bullet_active), 32'h7);
        end
`ifdef BULLET_POOL_EDGE_FIRE_EN
        exp_pulses = 1;
`else
        exp_pulses = 3;
`endif
        check("hold_pulses", pulses, exp_pulses);
        for (int k = 20; k < 29; k++) frame_step("fill");
`ifndef BULLET_POOL_EDGE_FIRE_EN
        check("pool_full", 32'(bullet_active), 32'hf);
        check("pool_full_pulse", 32'(fire_pulse), 0);
`endif
        bullet_hit = 4'b0100;
        frame_step("hit2");
        bullet_hit = '0;
`ifndef BULLET_POOL_EDGE_FIRE_EN
        check("hit2_retired", 32'(bullet_active), 32'hb);
`endif
        frame_step("refire");
`ifndef BULLET_POOL_EDGE_FIRE_EN
        check("refire_slot2", 32'(bullet_active), 32'hf);
        check("refire_y2", 32'(bullet_Y_out[29:20]), 400);
`endif

        // Retire threshold: Y=19 retires immediately, Y=20 moves once then retires.
        do_reset("rst_c");
        ship_Y    = 10'd19;
        space_key = make_key(1);
        frame_step("y19_fire");
        space_key = make_key(0);
        frame_step("y19_ret");
        check("y19_gone", 32'(bullet_active[0]), 0);
        check("y19_frozen", 32'(bullet_Y_out[9:0]), 19);
        for (int k = 0; k < 6; k++) frame_step("cool");
        ship_Y    = 10'd20;
        space_key = make_key(1);
        frame_step("y20_fire");
        space_key = make_key(0);
        frame_step("y20_move");
        check("y20_moved", 32'(bullet_Y_out[9:0]), 12);
        check("y20_alive", 32'(bullet_active[0]), 1);
        frame_step("y20_ret");
        check("y20_gone", 32'(bullet_active[0]), 0);

        // Hits on idle slots and ship at the top bound: nothing happens.
        do_reset("rst_d");
        ship_Y     = 10'd15;
        space_key  = make_key(1);
        bullet_hit = '1;
        for (int k = 0; k < 3; k++) frame_step("idle");
        check("idle_active", 32'(bullet_active), 0);
        check("idle_pulse", 32'(fire_pulse), 0);
        bullet_hit = '0;

        // Randomised traffic with occasional asynchronous resets.
        do_reset("rst_e");
        for (int k = 0; k < 400; k++) begin
            ship_X     = 10'($urandom_range(0, 639));
            ship_Y     = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 22))
                                                     : 10'($urandom_range(15, 479));
            space_key  = make_key($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) bullet_hit[i] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
            frame_step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
